// File: rtl/nbody_block_scheduler_if.sv
// Handshake bundle between the n-body block scheduler, the systolic array and the integrator.
// master = scheduler side, slave = array/integrator/controller side.
interface nbody_block_scheduler_if #(
  parameter int N_BODIES = 8,
  parameter int TILE     = 2
);
  localparam int NB = N_BODIES / TILE;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;

  logic          start;
  logic [15:0]   num_steps;
  logic          busy;
  logic          done;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] blk_i;
  logic [BW-1:0] blk_j;
  logic          blk_diag;
  logic          res_valid;
  logic          int_valid;
  logic          int_ready;
  logic [IW-1:0] int_body;
  logic [15:0]   step_cnt;
  logic          err;

  modport master (
    input  start, num_steps, blk_ready, res_valid, int_ready,
    output busy, done, blk_valid, blk_i, blk_j, blk_diag, int_valid, int_body, step_cnt, err
  );

  modport slave (
    output start, num_steps, blk_ready, res_valid, int_ready,
    input  busy, done, blk_valid, blk_i, blk_j, blk_diag, int_valid, int_body, step_cnt, err
  );
endinterface

// File: rtl/nbody_block_scheduler.sv
// Tiled n-body timestep scheduler: issues force blocks (first descriptor 1 cycle after start), drains, then integrates.
// Issue stalls at MAX_OUTST in flight or !blk_ready; integration stalls on !int_ready. NBODY_SCHED_SYMMETRY_EN: upper triangle only.
module nbody_block_scheduler #(
  parameter int N_BODIES  = 8,
  parameter int TILE      = 2,
  parameter int MAX_OUTST = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  nbody_block_scheduler_if.master bus
);
  localparam int NB = N_BODIES / TILE;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [BW-1:0] BLK_LAST  = BW'(NB - 1);
  localparam logic [IW-1:0] BODY_LAST = IW'(N_BODIES - 1);
  localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTST);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_INTEG = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state;
  logic [15:0]   steps_q;
  logic [15:0]   step_cnt_q;
  logic [OW-1:0] outst;
  logic [BW-1:0] bi;
  logic [BW-1:0] bj;
  logic [IW-1:0] body;
  logic          err_q;
  logic          blk_hs;
  logic          int_hs;
  logic          row_end;
  logic          last_blk;

  assign bus.blk_valid = (state == S_ISSUE) && (outst != OUT_MAX);
  assign bus.int_valid = (state == S_INTEG);
  assign bus.busy      = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_INTEG);
  assign bus.done      = (state == S_FIN);
  assign bus.blk_i     = bi;
  assign bus.blk_j     = bj;
  assign bus.blk_diag  = (bi == bj);
  assign bus.int_body  = body;
  assign bus.step_cnt  = step_cnt_q;
  assign bus.err       = err_q;

  assign blk_hs   = bus.blk_valid && bus.blk_ready;
  assign int_hs   = bus.int_valid && bus.int_ready;
  assign row_end  = (bj == BLK_LAST);
  assign last_blk = row_end && (bi == BLK_LAST);

  // A result with nothing in flight, or outside a run, is a protocol error; the counter never underflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.res_valid && ((outst == '0) || (state == S_IDLE) || (state == S_FIN)))
        err_q <= 1'b1;
      if (blk_hs && !bus.res_valid)
        outst <= outst + OW'(1);
      else if (!blk_hs && bus.res_valid && (outst != '0))
        outst <= outst - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      steps_q    <= '0;
      step_cnt_q <= '0;
      bi         <= '0;
      bj         <= '0;
      body       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            steps_q    <= bus.num_steps;
            step_cnt_q <= '0;
            bi         <= '0;
            bj         <= '0;
            body       <= '0;
            state      <= (bus.num_steps == 16'd0) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (blk_hs) begin
            if (last_blk) begin
              bi    <= '0;
              bj    <= '0;
              state <= S_DRAIN;
            end else if (row_end) begin
              bi <= bi + BW'(1);
`ifdef NBODY_SCHED_SYMMETRY_EN
              bj <= bi + BW'(1);
`else
              bj <= '0;
`endif
            end else begin
              bj <= bj + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (outst == '0)
            state <= S_INTEG;
        end
        S_INTEG: begin
          if (int_hs) begin
            if (body == BODY_LAST) begin
              body       <= '0;
              step_cnt_q <= step_cnt_q + 16'd1;
              state      <= ((step_cnt_q + 16'd1) == steps_q) ? S_FIN : S_ISSUE;
            end else begin
              body <= body + IW'(1);
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nbody_block_scheduler.sv
// Randomised bench for nbody_block_scheduler against a queue-based model of the block/integration order.
// Also exercises in-flight limiting, zero-step runs and mid-run reset.
module tb_nbody_block_scheduler;
  localparam int N_BODIES  = 8;
  localparam int TILE      = 2;
  localparam int MAX_OUTST = 4;
  localparam int NB        = N_BODIES / TILE;
  localparam int BW        = $clog2(NB);
`ifdef NBODY_SCHED_SYMMETRY_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nbody_block_scheduler_if #(.N_BODIES(N_BODIES), .TILE(TILE)) bus ();

  nbody_block_scheduler #(.N_BODIES(N_BODIES), .TILE(TILE), .MAX_OUTST(MAX_OUTST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [2*BW-1:0] exp_blk[$];
  int              exp_int[$];
  int              res_due[$];
  int              cycle = 0;
  int              rdy_pct = 100;
  bit              res_manual = 1'b0;
  logic            res_force = 1'b0;
  int              done_cnt = 0;
  int              valid_cycles = 0;
  bit              blk_stall = 1'b0;
  bit              int_stall = 1'b0;
  logic [2*BW-1:0] stall_ij;
  logic [31:0]     stall_body;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_blk_valid", 32'(bus.blk_valid), 0);
    check("rst_int_valid", 32'(bus.int_valid), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_blk_ij", 32'({bus.blk_i, bus.blk_j}), 0);
    check("rst_blk_diag", 32'(bus.blk_diag), 1);
    check("rst_int_body", 32'(bus.int_body), 0);
    check("rst_step_cnt", 32'(bus.step_cnt), 0);
  endtask

  // One clock cycle: drive inputs at the falling edge, observe and score, advance.
  task automatic cyc();
    logic            rv;
    logic [2*BW-1:0] ij;
    logic [2*BW-1:0] e;
    int              eb;
    rv = 1'b0;
    if (res_manual) rv = res_force;
    else if (res_due.size() > 0 && res_due[0] <= cycle) rv = 1'b1;
    if (rv && res_due.size() > 0) void'(res_due.pop_front());
    bus.res_valid = rv;
    bus.blk_ready = ($urandom_range(99) < rdy_pct);
    bus.int_ready = ($urandom_range(99) < rdy_pct);
    ij = {bus.blk_i, bus.blk_j};

    if (blk_stall) begin
      check("blk_hold_valid", 32'(bus.blk_valid), 1);
      check("blk_hold_ij", 32'(ij), 32'(stall_ij));
    end
    if (int_stall) begin
      check("int_hold_valid", 32'(bus.int_valid), 1);
      check("int_hold_body", 32'(bus.int_body), stall_body);
    end
    check("valid_exclusive", 32'(bus.blk_valid & bus.int_valid), 0);
    if (bus.blk_valid || bus.int_valid) valid_cycles++;

    if (bus.blk_valid && bus.blk_ready) begin
      check("blk_expected", 32'(exp_blk.size() > 0), 1);
      if (exp_blk.size() > 0) begin
        e = exp_blk.pop_front();
        check("blk_ij", 32'(ij), 32'(e));
        check("blk_diag", 32'(bus.blk_diag), 32'(e[2*BW-1:BW] == e[BW-1:0]));
      end
      res_due.push_back(cycle + 2);
    end
    if (bus.int_valid && bus.int_ready) begin
      check("int_expected", 32'(exp_int.size() > 0), 1);
      if (exp_int.size() > 0) begin
        eb = exp_int.pop_front();
        check("int_body", 32'(bus.int_body), 32'(eb));
      end
    end
    blk_stall  = bus.blk_valid && !bus.blk_ready;
    stall_ij   = ij;
    int_stall  = bus.int_valid && !bus.int_ready;
    stall_body = 32'(bus.int_body);
    if (bus.done) begin
      done_cnt++;
      check("busy_low_at_done", 32'(bus.busy), 0);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic prep(input int n);
    exp_blk.delete();
    exp_int.delete();
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < NB; i++)
        for (int j = (SYM ? i : 0); j < NB; j++)
          exp_blk.push_back({BW'(i), BW'(j)});
      for (int b = 0; b < N_BODIES; b++)
        exp_int.push_back(b);
    end
    done_cnt     = 0;
    valid_cycles = 0;
    blk_stall    = 1'b0;
    int_stall    = 1'b0;
  endtask

  task automatic kick(input int n);
    bus.num_steps = 16'(n);
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'(n > 0));
    if (n > 0) check("first_blk_latency", 32'(bus.blk_valid), 1);
  endtask

  task automatic finish(input int n);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) cyc();
    repeat (3) cyc();
    check("done_pulses", done_cnt, 1);
    check("blk_all_issued", exp_blk.size(), 0);
    check("int_all_done", exp_int.size(), 0);
    check("step_cnt_final", 32'(bus.step_cnt), 32'(n));
    check("err_clean", 32'(bus.err), 0);
    check("busy_idle", 32'(bus.busy), 0);
    if (n == 0) check("no_valid_zero_steps", valid_cycles, 0);
  endtask

  task automatic run(input int n, input int pct);
    rdy_pct    = pct;
    res_manual = 1'b0;
    prep(n);
    kick(n);
    finish(n);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.num_steps = '0;
    bus.blk_ready = 1'b0;
    bus.int_ready = 1'b0;
    bus.res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    run(1, 100);
    run(2, 100);
    run(2, 60);
    run(3, 35);
    run(0, 100);

    // In-flight limit: withhold results until issue stops at MAX_OUTST.
    rdy_pct    = 100;
    res_manual = 1'b1;
    res_force  = 1'b0;
    prep(1);
    kick(1);
    repeat (6) cyc();
    check("limit_blk_valid_low", 32'(bus.blk_valid), 0);
    check("limit_outstanding", res_due.size(), MAX_OUTST);
    res_force = 1'b1;
    cyc();
    res_force = 1'b0;
    check("limit_reenabled", 32'(bus.blk_valid), 1);
    res_force = 1'b1;
    cyc();
    res_force = 1'b0;
    check("limit_same_cycle_valid", 32'(bus.blk_valid), 1);
    cyc();
    check("limit_full_again", 32'(bus.blk_valid), 0);
    res_manual = 1'b0;
    finish(1);

    // Reset mid-run with results still in flight.
    rdy_pct    = 100;
    res_manual = 1'b1;
    res_force  = 1'b0;
    prep(2);
    kick(2);
    repeat (2) cyc();
    check("pre_reset_in_flight", 32'(res_due.size() > 0), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    blk_stall = 1'b0;
    int_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    res_force = 1'b1;
    cyc();
    res_force = 1'b0;
    check("err_spurious_result", 32'(bus.err), 1);
    repeat (2) cyc();
    check("err_sticky", 32'(bus.err), 1);
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", 32'(bus.busy), 0);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_reset", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_due.delete();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
